// File: rtl/count_checker.sv
// count_checker: verifies that an observed count advances by one per clock, locking after LOCK_N matches and flagging breaks.
//   clk     : sole clock, all state updates on rising edge
//   rstn    : synchronous active-low reset, overrides every other input
//   cnt     : count under observation, sampled every edge
//   clr     : synchronous clear of err_cnt and bad_cnt
//   locked  : high while tracking a verified sequence
//   err     : one-cycle pulse per sequence break seen while locked
//   err_cnt : saturating error count
//   exp_cnt : value expected at the next sample
//   bad_cnt : cnt value captured at the most recent error
module count_checker #(
  parameter int WIDTH  = 32,
  parameter int ERR_W  = 16,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cnt,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] exp_cnt,
  output logic [WIDTH-1:0] bad_cnt
);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  state_t state, state_nx;
  logic [3:0] mcnt, mcnt_nx;
  logic hit, brk, locked_nx, err_nx;
  logic [ERR_W-1:0] err_cnt_nx;
  logic [WIDTH-1:0] exp_nx, bad_nx;
  assign hit = cnt == exp_cnt;
  // Only a break while locked is an error; misses during acquisition just restart it.
  assign brk = state == TRACK && !hit;
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? ACQ :
               state == ACQ  ? ((hit && mcnt + 4'd1 == 4'(LOCK_N)) ? TRACK : ACQ) :
               (hit ? TRACK : ACQ);
  always_comb begin
    exp_nx     = (state != IDLE && hit) ? exp_cnt + 1'b1 : cnt + 1'b1;
    mcnt_nx    = (state == ACQ && hit) ? mcnt + 4'd1 : 4'd0;
    locked_nx  = state_nx == TRACK;
    err_nx     = brk;
    // Clear wins over accumulated history but an error on the same edge still counts once.
    err_cnt_nx = clr ? ERR_W'(brk) : (brk && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    bad_nx     = brk ? cnt : clr ? '0 : bad_cnt;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      mcnt    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      exp_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      mcnt    <= mcnt_nx;
      locked  <= locked_nx;
      err     <= err_nx;
      err_cnt <= err_cnt_nx;
      exp_cnt <= exp_nx;
      bad_cnt <= bad_nx;
    end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: randomized and directed scoreboard bench for count_checker.
module tb_count_checker;
  localparam int W = 32, EW = 4, LN = 4;
  logic clk = 0, rstn = 0, clr = 0;
  logic [W-1:0] cnt = '0;
  logic locked, err;
  logic [EW-1:0] err_cnt;
  logic [W-1:0] exp_cnt, bad_cnt;
  typedef struct packed {logic locked; logic err; logic [EW-1:0] ec; logic [W-1:0] exp; logic [W-1:0] bad;} out_t;
  out_t q[$];
  int checks = 0, failures = 0;
  bit started = 0, m_locked = 0;
  int run = 0;
  logic [W-1:0] m_exp = '0, m_bad = '0, cv = '0;
  logic [EW-1:0] m_ec = '0;
  logic m_err = 0;
  count_checker #(.WIDTH(W), .ERR_W(EW), .LOCK_N(LN)) dut (
    .clk(clk), .rstn(rstn), .cnt(cnt), .clr(clr), .locked(locked), .err(err),
    .err_cnt(err_cnt), .exp_cnt(exp_cnt), .bad_cnt(bad_cnt));
  always #5 clk = ~clk;
  task automatic step(input logic [W-1:0] c, input logic cl = 0, input logic rn = 1);
    logic e;
    cnt = c; clr = cl; rstn = rn;
    e = 0;
    if (!rn) begin
      started = 0; m_locked = 0; run = 0; m_exp = '0; m_bad = '0; m_ec = '0;
    end else begin
      if (!started) begin
        started = 1; m_exp = c + 1; run = 0;
      end else if (c == m_exp) begin
        m_exp = c + 1;
        if (!m_locked) begin
          run++;
          if (run == LN) m_locked = 1;
        end
      end else begin
        e = m_locked;
        m_locked = 0; run = 0; m_exp = c + 1;
      end
      if (cl) m_ec = e ? 1 : 0;
      else if (e && m_ec != {EW{1'b1}}) m_ec = m_ec + 1;
      m_bad = e ? c : cl ? '0 : m_bad;
    end
    m_err = e;
    q.push_back('{m_locked, m_err, m_ec, m_exp, m_bad});
    @(negedge clk);
  endtask
  task automatic seq(input logic [W-1:0] start, input int n);
    for (int i = 0; i < n; i++) step(start + W'(i));
  endtask
  initial begin
    out_t a, x;
    forever begin
      @(posedge clk); #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        a = '{locked, err, err_cnt, exp_cnt, bad_cnt};
        checks++;
        if (a !== x) begin
          failures++;
          $display("FAIL outputs t=%0t got locked=%0b err=%0b err_cnt=%0d exp_cnt=%h bad_cnt=%h want locked=%0b err=%0b err_cnt=%0d exp_cnt=%h bad_cnt=%h",
                   $time, a.locked, a.err, a.ec, a.exp, a.bad, x.locked, x.err, x.ec, x.exp, x.bad);
        end
      end
    end
  end
  initial begin
    int r, guard;
    step(0, 1, 0); step(5, 0, 0);
    seq(0, 6);
    seq(6, 5); step(12); seq(13, 4); seq(17, 3);
    seq(32'hFFFF_FFFC, 6);
    seq(7, 2); seq(0, 5); seq(5, 3);
    seq(7, 2); step(0, 0, 0); seq(0, 6);
    for (int k = 0; k < 18; k++) begin
      seq(32'h100 * (k + 1), 5);
      step(32'h5000 + W'(k), k == 17);
    end
    seq(1, 6); step(7, 1); step(8, 1); seq(9, 3);
    step(9); step(50); step(77); seq(78, 6);
    cv = $urandom;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      cv = r < 82 ? cv + 1 : r < 88 ? cv : r < 94 ? W'($urandom) : r < 97 ? 32'hFFFF_FFFD : cv + 2;
      step(cv, $urandom_range(0, 19) == 0, $urandom_range(0, 59) != 0);
    end
    guard = 0;
    while (q.size() != 0 && guard < 10) begin @(negedge clk); guard++; end
    if (q.size() != 0) begin
      failures++; checks++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter WIDTH, default 32, width of the observed count.
REQ-002 Parameter ERR_W, default 16, width of the error counter.
REQ-003 Parameter LOCK_N, default 4, range 1..15; consecutive matches needed to declare lock.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 cnt  input  WIDTH  count value under observation, sampled every rising edge.
REQ-007 clr  input  1  synchronous clear of err_cnt and bad_cnt, active high.
REQ-008 locked  output  1  high while the checker is tracking a verified sequence.
REQ-009 err  output  1  one-cycle pulse per detected sequence break.
REQ-010 err_cnt  output  ERR_W  saturating count of errors.
REQ-011 exp_cnt  output  WIDTH  value expected at the next sample.
REQ-012 bad_cnt  output  WIDTH  cnt value captured at the most recent error.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from input to output.
REQ-014 The FSM SHALL have exactly three states: IDLE, ACQ, TRACK.
REQ-015 IDLE, first edge with rstn=1: exp_cnt <= cnt+1, match counter <= 0, next state ACQ.
REQ-016 ACQ, cnt==exp_cnt: exp_cnt <= exp_cnt+1 and match counter increments.
REQ-017 ACQ, when the match counter reaches LOCK_N: next state TRACK, locked <= 1.
REQ-018 ACQ, cnt!=exp_cnt: exp_cnt <= cnt+1, match counter <= 0, stay in ACQ, no err pulse and no err_cnt change.
REQ-019 TRACK, cnt==exp_cnt: exp_cnt <= exp_cnt+1, no other change.
REQ-020 TRACK, cnt!=exp_cnt, all on the same edge:
- err <= 1 for one cycle
- err_cnt increments
- bad_cnt <= cnt
- exp_cnt <= cnt+1
- match counter <= 0
- locked <= 0
- next state ACQ
REQ-021 err SHALL be high only in the cycle immediately after the edge that sampled the mismatch.
REQ-022 A mismatch on consecutive edges in TRACK then ACQ SHALL produce exactly one err pulse.
REQ-023 Increment arithmetic SHALL be modulo 2^WIDTH: all-ones followed by 0 is a match, not an error.
REQ-024 err_cnt SHALL saturate at all-ones; further errors still pulse err and update bad_cnt.
REQ-025 clr=1 with no error on the same edge: err_cnt <= 0, bad_cnt <= 0.
REQ-026 clr=1 with an error on the same edge: err_cnt <= 1, bad_cnt <= cnt.
REQ-027 clr SHALL NOT affect the FSM state, exp_cnt, locked or err.
REQ-028 A held (non-incrementing) cnt in TRACK SHALL be a mismatch on the first repeated sample.

Reset
REQ-029 On any edge with rstn=0, regardless of state or clr:
- state <= IDLE
- locked, err <= 0
- err_cnt, bad_cnt, exp_cnt <= 0
- match counter <= 0
REQ-030 Reset asserted mid-sequence (including in TRACK or during an err pulse) SHALL discard all history; reacquisition SHALL restart per REQ-015.
REQ-031 rstn SHALL take priority over every other input.

Verification
REQ-032 Reset, then cnt=0,1,2,3,4,5 -> locked=1 in the cycle after the edge sampling 4; err never asserts; exp_cnt=6 after sampling 5.
REQ-033 Locked, cnt ...,9,10,12,13,14,15,16 -> one err pulse after 12; err_cnt=1, bad_cnt=12, exp_cnt=13, locked=0; locked=1 again after 16 is sampled.
REQ-034 Locked, cnt=FFFFFFFE,FFFFFFFF,0,1 -> no err, locked stays 1, exp_cnt=2.
REQ-035 Locked, counter restarted at 0 without checker reset (cnt 7,8,0,1,2,3,4) -> one err, bad_cnt=0, relock after 4 is sampled; with rstn=0 applied instead -> no err, all outputs 0.
REQ-036 ERR_W=4, 17 forced TRACK errors -> err_cnt=15 and holds; clr on the edge of an 18th error -> err_cnt=1.
REQ-037 clr pulse while locked with no error -> err_cnt=0, bad_cnt=0; locked and exp_cnt unchanged.
